// File: rtl/cas_player_pkg.sv
// Shared types and constants for the CoCo cassette playback transmitter.
// The state encoding is shared by the FSM and anything that decodes it.
package cas_player_pkg;

    localparam int unsigned CAS_CLK_HZ    = 32'd57272000;
    localparam int unsigned HALF_ZERO_DEF = 32'd23863;   // 1200 Hz half-period at CAS_CLK_HZ
    localparam int unsigned HALF_ONE_DEF  = 32'd11932;   // 2400 Hz half-period at CAS_CLK_HZ

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HI    = 3'd3,
        ST_LO    = 3'd4,
        ST_DONE  = 3'd5
    } cas_state_e;

endpackage

// File: rtl/cas_fsk_gen.sv
// One-bit FSK cell: a square cycle (high half, then low half) whose half-period
// depends on the bit value. Counting freezes whenever i_run is low.
module cas_fsk_gen
    import cas_player_pkg::*;
#(
    parameter int unsigned HALF_ZERO = HALF_ZERO_DEF,
    parameter int unsigned HALF_ONE  = HALF_ONE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_bit,
    input  logic i_run,
    output logic o_casdout,
    output logic o_half_end,
    output logic o_bit_end
);

    localparam logic [15:0] RELOAD_ZERO = 16'(HALF_ZERO - 32'd1);
    localparam logic [15:0] RELOAD_ONE  = 16'(HALF_ONE - 32'd1);

    logic [15:0] r_cnt;
    logic        r_bit;
    logic        r_phase_lo;
    logic        r_active;
    logic        r_casdout;
    logic        w_step;
    logic        w_cnt_zero;

    assign w_step     = i_run & r_active;
    assign w_cnt_zero = (r_cnt == 16'd0);
    assign o_half_end = w_step & w_cnt_zero & ~r_phase_lo;
    assign o_bit_end  = w_step & w_cnt_zero & r_phase_lo;
    assign o_casdout  = r_casdout;

    // Half counter and phase; a load on the bit-end cycle chains bits without a gap.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt      <= 16'd0;
            r_bit      <= 1'b0;
            r_phase_lo <= 1'b0;
            r_active   <= 1'b0;
            r_casdout  <= 1'b0;
        end else if (i_load) begin
            r_cnt      <= i_bit ? RELOAD_ONE : RELOAD_ZERO;
            r_bit      <= i_bit;
            r_phase_lo <= 1'b0;
            r_active   <= 1'b1;
            r_casdout  <= 1'b1;
        end else if (o_half_end) begin
            r_cnt      <= r_bit ? RELOAD_ONE : RELOAD_ZERO;
            r_phase_lo <= 1'b1;
            r_casdout  <= 1'b0;
        end else if (o_bit_end) begin
            r_active   <= 1'b0;
            r_phase_lo <= 1'b0;
            r_casdout  <= 1'b0;
        end else if (w_step) begin
            r_cnt      <= r_cnt - 16'd1;
        end
    end

endmodule

// File: rtl/cas_player.sv
// Cassette playback transmitter: streams a .cas byte buffer LSB first as CoCo FSK,
// gated by the motor relay and the user play enable, with a one-byte prefetch shadow.
module cas_player
    import cas_player_pkg::*;
#(
    parameter int unsigned HALF_ZERO = HALF_ZERO_DEF,
    parameter int unsigned HALF_ONE  = HALF_ONE_DEF,
    parameter int unsigned AW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          motor,
    input  logic          play,
    input  logic          rewind,
    input  logic [AW-1:0] length,
    output logic          buf_rd,
    output logic [AW-1:0] buf_addr,
    input  logic [7:0]    buf_data,
    output logic          casdout,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pos
);

    cas_state_e    r_state;
    cas_state_e    w_state_nx;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_pos;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shadow;
    logic          r_shadow_vld;
    logic          r_pf_cap;
    logic          r_buf_rd;
    logic [AW-1:0] r_buf_addr;
    logic          r_busy;
    logic          r_done;

    logic          w_run;
    logic          w_load;
    logic          w_load_bit;
    logic          w_fetch;
    logic          w_pf_req;
    logic [AW-1:0] w_pf_addr;
    logic          w_half_end;
    logic          w_bit_end;
    logic [AW:0]   w_pos_p1;
    logic [AW:0]   w_pos_p2;
    logic [AW:0]   w_len_x;

    assign w_run    = motor & play;
    assign w_pos_p1 = {1'b0, r_pos} + {{AW{1'b0}}, 1'b1};
    assign w_pos_p2 = {1'b0, r_pos} + {{(AW-1){1'b0}}, 2'b10};
    assign w_len_x  = {1'b0, r_len};

    // Next-state decode, bit hand-off to the FSK cell and read-strobe requests.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_load_bit = 1'b0;
        w_fetch    = 1'b0;
        w_pf_req   = 1'b0;
        w_pf_addr  = r_pos;
        case (r_state)
            ST_IDLE: begin
                if (r_pos >= length) begin
                    w_state_nx = ST_DONE;
                end else if (w_run) begin
                    w_state_nx = ST_FETCH;
                    w_fetch    = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_FETCH: w_state_nx = ST_LOAD;
            ST_LOAD: begin
                w_state_nx = ST_HI;
                w_load     = 1'b1;
                w_load_bit = buf_data[0];
                if (w_pos_p1 < w_len_x) begin
                    w_pf_req  = 1'b1;
                    w_pf_addr = w_pos_p1[AW-1:0];
                end else begin
                    w_pf_req  = 1'b0;
                end
            end
            ST_HI: begin
                if (w_half_end) begin
                    w_state_nx = ST_LO;
                end else begin
                    w_state_nx = ST_HI;
                end
            end
            ST_LO: begin
                if (!w_bit_end) begin
                    w_state_nx = ST_LO;
                end else if (r_bit_idx != 3'd7) begin
                    w_state_nx = ST_HI;
                    w_load     = 1'b1;
                    w_load_bit = r_shift[1];
                end else if (r_shadow_vld) begin
                    // Byte boundary: the shadow byte starts on the very next cycle.
                    w_state_nx = ST_HI;
                    w_load     = 1'b1;
                    w_load_bit = r_shadow[0];
                    if (w_pos_p2 < w_len_x) begin
                        w_pf_req  = 1'b1;
                        w_pf_addr = w_pos_p2[AW-1:0];
                    end else begin
                        w_pf_req  = 1'b0;
                    end
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: w_state_nx = ST_DONE;
            default: w_state_nx = ST_IDLE;
        endcase
        if (rewind) begin
            w_state_nx = ST_IDLE;
            w_load     = 1'b0;
            w_fetch    = 1'b0;
            w_pf_req   = 1'b0;
        end else begin
            w_state_nx = w_state_nx;
        end
    end

    // State register and registered status / buffer-strobe outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_buf_rd   <= 1'b0;
            r_buf_addr <= {AW{1'b0}};
            r_len      <= {AW{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx == ST_FETCH) || (w_state_nx == ST_LOAD) ||
                       (w_state_nx == ST_HI)    || (w_state_nx == ST_LO);
            r_done  <= (w_state_nx == ST_DONE);
            if (r_state == ST_IDLE) begin
                r_len <= length;
            end
            if (w_fetch) begin
                r_buf_rd   <= 1'b1;
                r_buf_addr <= r_pos;
            end else if (w_pf_req) begin
                r_buf_rd   <= 1'b1;
                r_buf_addr <= w_pf_addr;
            end else begin
                r_buf_rd   <= 1'b0;
            end
        end
    end

    // Byte pointer, shift register and prefetch shadow.
    always_ff @(posedge clk) begin
        if (reset || rewind) begin
            r_pos        <= {AW{1'b0}};
            r_shift      <= 8'd0;
            r_bit_idx    <= 3'd0;
            r_shadow     <= 8'd0;
            r_shadow_vld <= 1'b0;
            r_pf_cap     <= 1'b0;
        end else begin
            // A strobe outside FETCH is a prefetch; its data arrives one cycle later.
            r_pf_cap <= r_buf_rd & (r_state != ST_FETCH);
            if (r_pf_cap) begin
                r_shadow     <= buf_data;
                r_shadow_vld <= 1'b1;
            end
            if (r_state == ST_LOAD) begin
                r_shift   <= buf_data;
                r_bit_idx <= 3'd0;
            end else if ((r_state == ST_LO) && w_bit_end) begin
                if (r_bit_idx != 3'd7) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end else begin
                    r_pos        <= w_pos_p1[AW-1:0];
                    r_shift      <= r_shadow;
                    r_bit_idx    <= 3'd0;
                    r_shadow_vld <= 1'b0;
                end
            end
        end
    end

    cas_fsk_gen #(
        .HALF_ZERO (HALF_ZERO),
        .HALF_ONE  (HALF_ONE)
    ) u_fsk (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (rewind),
        .i_load     (w_load),
        .i_bit      (w_load_bit),
        .i_run      (w_run),
        .o_casdout  (casdout),
        .o_half_end (w_half_end),
        .o_bit_end  (w_bit_end)
    );

    assign buf_rd   = r_buf_rd;
    assign buf_addr = r_buf_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pos      = r_pos;

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player with HALF_ZERO=8, HALF_ONE=4: start latency,
// waveform shape, gap-free bytes, pause, empty tape, rewind and mid-run reset.
module tb_cas_player;

    localparam int H0 = 8;
    localparam int H1 = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        motor;
    logic        play;
    logic        rewind;
    logic [15:0] length;
    logic        buf_rd;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;
    logic        casdout;
    logic        busy;
    logic        done;
    logic [15:0] pos;

    logic [7:0]  mem [0:3];
    int          n_checks = 0;
    int          n_fail   = 0;

    cas_player #(.HALF_ZERO(H0), .HALF_ONE(H1), .AW(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .motor    (motor),
        .play     (play),
        .rewind   (rewind),
        .length   (length),
        .buf_rd   (buf_rd),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .casdout  (casdout),
        .busy     (busy),
        .done     (done),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    // Buffer memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (buf_rd) buf_data <= mem[buf_addr[1:0]];
    end

    // Expected tape level at waveform cycle idx for 'data' sent LSB first.
    function automatic logic exp_level(input logic [15:0] data, input int idx);
        int t;
        int h;
        t = idx;
        for (int b = 0; b < 16; b++) begin
            h = data[b] ? H1 : H0;
            if (t < h) return 1'b1;
            if (t < 2 * h) return 1'b0;
            t = t - 2 * h;
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b1; motor = 1'b0; play = 1'b0; rewind = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        length = 16'd1;
        reset = 1'b1; motor = 1'b1; play = 1'b1; rewind = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({casdout, buf_rd, busy, done} !== 4'b0000 || buf_addr !== 16'd0 || pos !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: casdout=%b buf_rd=%b busy=%b done=%b buf_addr=%0d pos=%0d required all 0",
                     casdout, buf_rd, busy, done, buf_addr, pos);
        end
        reset = 1'b0; motor = 1'b0; play = 1'b0;
    endtask

    task automatic test_basic_byte();
        logic e;
        int   rd;
        mem[0] = 8'hA5; length = 16'd1;
        do_reset();
        motor = 1'b1; play = 1'b1;
        @(negedge clk);
        n_checks++;
        if (buf_rd !== 1'b1 || buf_addr !== 16'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fetch: buf_rd=%b addr=%0d busy=%b required 1/0/1", buf_rd, buf_addr, busy);
        end
        length = 16'd3;  // must be ignored outside IDLE
        @(negedge clk);
        n_checks++;
        if (buf_rd !== 1'b0 || casdout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_load: buf_rd=%b casdout=%b required 0/0", buf_rd, casdout);
        end
        rd = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (buf_rd) rd++;
            e = exp_level(16'h00A5, i);
            n_checks++;
            if (casdout !== e) begin
                n_fail++;
                $display("FAIL basic_wave[%0d]: casdout=%b required %b", i, casdout, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || pos !== 16'd1 || casdout !== 1'b0 || busy !== 1'b0 || rd != 0) begin
            n_fail++;
            $display("FAIL basic_end: done=%b pos=%0d casdout=%b busy=%b reads=%0d required 1/1/0/0/0",
                     done, pos, casdout, busy, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic        e;
        int          rd;
        logic [15:0] pf_addr;
        mem[0] = 8'h00; mem[1] = 8'hFF; length = 16'd2;
        do_reset();
        motor = 1'b1; play = 1'b1;
        rd = 0; pf_addr = 16'hFFFF;
        @(negedge clk);
        if (buf_rd) rd++;
        @(negedge clk);
        if (buf_rd) rd++;
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            if (buf_rd) begin rd++; pf_addr = buf_addr; end
            e = exp_level(16'hFF00, i);
            n_checks++;
            if (casdout !== e) begin
                n_fail++;
                $display("FAIL b2b_wave[%0d]: casdout=%b required %b", i, casdout, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if (rd != 2 || pf_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_reads: count=%0d prefetch_addr=%0d required 2/1", rd, pf_addr);
        end
        n_checks++;
        if (done !== 1'b1 || pos !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_end: done=%b pos=%0d required 1/2", done, pos);
        end
    endtask

    task automatic test_motor_pause();
        logic e;
        mem[0] = 8'hA5; length = 16'd1;
        do_reset();
        motor = 1'b1; play = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 133; i++) begin
            @(negedge clk);
            if (i <= 34)      e = exp_level(16'h00A5, i);
            else if (i <= 71) e = exp_level(16'h00A5, 34);
            else              e = exp_level(16'h00A5, i - 37);
            n_checks++;
            if (casdout !== e) begin
                n_fail++;
                $display("FAIL pause_wave[%0d]: casdout=%b required %b", i, casdout, e);
            end
            if (i == 34) motor = 1'b0;
            if (i == 71) motor = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || pos !== 16'd1) begin
            n_fail++;
            $display("FAIL pause_end: done=%b pos=%0d required 1/1", done, pos);
        end
    endtask

    task automatic test_empty_and_rewind_run();
        int rd;
        length = 16'd0;
        do_reset();
        motor = 1'b1; play = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || casdout !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_done: done=%b casdout=%b busy=%b required 1/0/0", done, casdout, busy);
        end
        rd = (buf_rd === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (buf_rd) rd++;
        end
        n_checks++;
        if (rd != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_reads: reads=%0d done=%b required 0/1", rd, done);
        end
        play = 1'b0;
        @(negedge clk);
        mem[0] = 8'hA5; length = 16'd1; play = 1'b1; rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || buf_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rewind_wins: done=%b busy=%b buf_rd=%b required 0/0/0", done, busy, buf_rd);
        end
        @(negedge clk);
        n_checks++;
        if (buf_rd !== 1'b1 || buf_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL rewind_fetch: buf_rd=%b addr=%0d required 1/0", buf_rd, buf_addr);
        end
    endtask

    task automatic test_rewind_mid_byte();
        logic e;
        mem[0] = 8'h00; mem[1] = 8'hFF; length = 16'd2;
        do_reset();
        motor = 1'b1; play = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            e = exp_level(16'hFF00, i);
            n_checks++;
            if (casdout !== e) begin
                n_fail++;
                $display("FAIL rew_wave[%0d]: casdout=%b required %b", i, casdout, e);
            end
        end
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        n_checks++;
        if (casdout !== 1'b0 || pos !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rew_state: casdout=%b pos=%0d busy=%b required 0/0/0", casdout, pos, busy);
        end
        @(negedge clk);
        n_checks++;
        if (buf_rd !== 1'b1 || buf_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL rew_refetch: buf_rd=%b addr=%0d required 1/0", buf_rd, buf_addr);
        end
        @(negedge clk);
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            e = exp_level(16'hFF00, i);
            n_checks++;
            if (casdout !== e) begin
                n_fail++;
                $display("FAIL rew_replay[%0d]: casdout=%b required %b", i, casdout, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || pos !== 16'd2) begin
            n_fail++;
            $display("FAIL rew_end: done=%b pos=%0d required 1/2", done, pos);
        end
    endtask

    task automatic test_reset_mid_run();
        mem[0] = 8'h00; mem[1] = 8'hFF; length = 16'd2;
        do_reset();
        motor = 1'b1; play = 1'b1;
        repeat (2) @(negedge clk);
        repeat (134) @(negedge clk);
        n_checks++;
        if (pos !== 16'd1 || busy !== 1'b1 || buf_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_pre: pos=%0d busy=%b addr=%0d required 1/1/1", pos, busy, buf_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({casdout, buf_rd, busy, done} !== 4'b0000 || buf_addr !== 16'd0 || pos !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid: casdout=%b buf_rd=%b busy=%b done=%b addr=%0d pos=%0d required all 0",
                     casdout, buf_rd, busy, done, buf_addr, pos);
        end
        @(negedge clk);
        n_checks++;
        if (buf_rd !== 1'b1 || buf_addr !== 16'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_refetch: buf_rd=%b addr=%0d busy=%b required 1/0/1", buf_rd, buf_addr, busy);
        end
    endtask

    initial begin
        reset = 1'b1; motor = 1'b0; play = 1'b0; rewind = 1'b0; length = 16'd0;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        test_reset();
        test_basic_byte();
        test_back_to_back();
        test_motor_pause();
        test_empty_and_rewind_run();
        test_rewind_mid_byte();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
